rs_scheduler: RTL
=================

RS_SCHEDULER -- requirements
Module: rs_scheduler

Interface
REQ-001 Parameter DEPTH, default 8, is the number of reservation-station entries (power of two, 2..16).
REQ-002 Parameter PADDR_W, default 6, is the physical-register tag width.
REQ-003 Parameter TAG_W, default 5, is the ROB-tag payload width carried per entry.
REQ-004 Port clk  input  1  is the single clock; all state is updated on its rising edge.
REQ-005 Port rst  input  1  is the asynchronous, active-high reset.
REQ-006 Port flush  input  1  discards all entries (mispredict/exception).
REQ-007 Port alloc_valid  input  1  indicates that dispatch presents an instruction.
REQ-008 Port alloc_ready  output  1  indicates that a free entry exists.
REQ-009 Ports alloc_rs1_paddr, alloc_rs2_paddr  input  PADDR_W  are the source physical tags.
REQ-010 Ports alloc_rs1_rdy, alloc_rs2_rdy  input  1  indicate that the source is already resolved at dispatch.
REQ-011 Port alloc_tag  input  TAG_W  is the ROB tag of the dispatched instruction.
REQ-012 Port wb_valid  input  1  indicates a writeback broadcast this cycle.
REQ-013 Port wb_paddr  input  PADDR_W  is the broadcast destination tag.
REQ-014 Port issue_valid  output  1  indicates that an entry with both sources ready is selected.
REQ-015 Port issue_ready  input  1  indicates that the functional unit accepts the selected entry.
REQ-016 Port issue_idx  output  $clog2(DEPTH)  is the selected entry index.
REQ-017 Port issue_tag  output  TAG_W  is the ROB tag of the selected entry.
REQ-018 Port count  output  $clog2(DEPTH)+1  is the number of occupied entries.

Function
REQ-019 Each entry SHALL hold: valid, rs1_rdy, rs2_rdy, rs1_paddr, rs2_paddr, tag.
REQ-020 alloc_ready SHALL be 1 iff count < DEPTH and flush = 0, based on registered state only (no path from issue_ready).
REQ-021 An allocation SHALL occur when alloc_valid & alloc_ready, writing the lowest-index invalid entry at the clock edge.
REQ-022 At allocation, rsN_rdy SHALL be stored as alloc_rsN_rdy | (wb_valid & wb_paddr == alloc_rsN_paddr) (same-cycle wakeup bypass).
REQ-023 Each cycle wb_valid is 1, every valid entry with rsN_rdy = 0 and rsN_paddr == wb_paddr SHALL set rsN_rdy = 1 at the edge; rs1 and rs2 are matched independently.
REQ-024 The select logic SHALL be combinational: issue_valid = OR over entries of (valid & rs1_rdy & rs2_rdy) & ~flush; issue_idx is the lowest such index; issue_tag is that entry's tag.
REQ-025 Wakeup SHALL become visible to select one cycle after the broadcast, with no same-cycle wb-to-issue path.
REQ-026 On issue_valid & issue_ready, the selected entry SHALL clear valid at the edge.
REQ-027 When issue_valid = 0, issue_idx and issue_tag SHALL be 0.
REQ-028 Simultaneous allocate and issue SHALL both take effect; count is unchanged; the freed entry is not reusable until the next cycle.
REQ-029 count SHALL be a register updated as count + alloc_fire - issue_fire; it never exceeds DEPTH or underflows.
REQ-030 flush = 1 SHALL clear all valid bits and count to 0 at the edge, ignore alloc/issue/wakeup that cycle, and hold alloc_ready = 0 and issue_valid = 0 combinationally.
REQ-031 A wakeup to a tag with no waiting entry SHALL have no effect; a duplicate wakeup SHALL be idempotent.

Reset
REQ-032 While rst = 1, all valid bits, rdy bits, paddr and tag fields, and count SHALL be 0 asynchronously.
REQ-033 During and after reset, outputs SHALL be alloc_ready = 1 (with flush = 0), issue_valid = 0, issue_idx = 0, issue_tag = 0, count = 0.
REQ-034 Reset asserted mid-operation SHALL discard all entries with no issue in the following cycle.

Verification
REQ-035 Fill: 8 allocs with rdy = 0/0, no wb -> count = 8, alloc_ready = 0, issue_valid = 0; a 9th alloc_valid is not accepted.
REQ-036 Wakeup: entry 3 waits on p12/p7; wb p12 then wb p7 -> issue_valid = 1 with issue_idx = 3 only in the cycle after the second broadcast.
REQ-037 Bypass: alloc rs1 = p5 (rdy = 0), rs2 rdy = 1, with wb_valid = 1 and wb_paddr = p5 in the same cycle -> issue_valid = 1 the next cycle.
REQ-038 Priority/backpressure: entries 1 and 4 ready, issue_ready = 0 -> issue_idx = 1 held stable; issue_ready = 1 -> entry 1 freed, then issue_idx = 4.
REQ-039 Full with concurrent alloc and issue: count = 8, issue fires -> next cycle count = 7 and alloc_ready = 1; alloc + issue together -> count stays 7.
REQ-040 Flush/reset: 5 entries, flush = 1 with alloc_valid = 1 -> next cycle count = 0, no entry is written; asynchronous rst mid-wakeup -> all outputs are at reset values immediately.

Source files
------------

// File: rtl/rs_scheduler.sv
// Reservation-station scheduler: allocates into the lowest free entry, wakes sources
// on writeback broadcasts and issues the lowest-index entry whose sources are ready.
module rs_scheduler #(
    parameter int DEPTH   = 8,
    parameter int PADDR_W = 6,
    parameter int TAG_W   = 5
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       alloc_valid,
    output logic                       alloc_ready,
    input  logic [PADDR_W-1:0]         alloc_rs1_paddr,
    input  logic [PADDR_W-1:0]         alloc_rs2_paddr,
    input  logic                       alloc_rs1_rdy,
    input  logic                       alloc_rs2_rdy,
    input  logic [TAG_W-1:0]           alloc_tag,
    input  logic                       wb_valid,
    input  logic [PADDR_W-1:0]         wb_paddr,
    output logic                       issue_valid,
    input  logic                       issue_ready,
    output logic [$clog2(DEPTH)-1:0]   issue_idx,
    output logic [TAG_W-1:0]           issue_tag,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = IDX_W + 1;

    logic [DEPTH-1:0]   valid_q;
    logic [DEPTH-1:0]   rs1_rdy_q;
    logic [DEPTH-1:0]   rs2_rdy_q;
    logic [PADDR_W-1:0] rs1_paddr_q [DEPTH];
    logic [PADDR_W-1:0] rs2_paddr_q [DEPTH];
    logic [TAG_W-1:0]   tag_q       [DEPTH];
    logic [CNT_W-1:0]   count_q;

    logic               free_found;
    logic [IDX_W-1:0]   free_idx;
    logic               sel_found;
    logic [IDX_W-1:0]   sel_idx;
    logic               alloc_fire;
    logic               issue_fire;
    logic               alloc_rs1_rdy_w;
    logic               alloc_rs2_rdy_w;

    // NOTE: every always_comb output gets a default before the loops so no latch is inferred.
    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        sel_found  = 1'b0;
        sel_idx    = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (!free_found && !valid_q[i]) begin
                free_found = 1'b1;
                free_idx   = IDX_W'(i);
            end
            if (!sel_found && valid_q[i] && rs1_rdy_q[i] && rs2_rdy_q[i]) begin
                sel_found = 1'b1;
                sel_idx   = IDX_W'(i);
            end
        end
    end

    // Select sees only registered ready bits, so a broadcast is visible one cycle later.
    assign alloc_ready = !flush && (count_q < CNT_W'(DEPTH));
    assign issue_valid = sel_found && !flush;
    assign issue_idx   = issue_valid ? sel_idx : '0;
    assign issue_tag   = issue_valid ? tag_q[sel_idx] : '0;
    assign count       = count_q;

    assign alloc_fire      = alloc_valid && alloc_ready;
    assign issue_fire      = issue_valid && issue_ready;
    assign alloc_rs1_rdy_w = alloc_rs1_rdy || (wb_valid && (wb_paddr == alloc_rs1_paddr));
    assign alloc_rs2_rdy_w = alloc_rs2_rdy || (wb_valid && (wb_paddr == alloc_rs2_paddr));

    // NOTE: the entry payload arrays are reset too, because the reset state of every field is defined.
    // NOTE: sequential state uses non-blocking assignments; a later write to the same bit wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q   <= '0;
            rs1_rdy_q <= '0;
            rs2_rdy_q <= '0;
            count_q   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                rs1_paddr_q[i] <= '0;
                rs2_paddr_q[i] <= '0;
                tag_q[i]       <= '0;
            end
        end else if (flush) begin
            valid_q <= '0;
            count_q <= '0;
        end else begin
            if (wb_valid) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (valid_q[i] && !rs1_rdy_q[i] && (rs1_paddr_q[i] == wb_paddr))
                        rs1_rdy_q[i] <= 1'b1;
                    if (valid_q[i] && !rs2_rdy_q[i] && (rs2_paddr_q[i] == wb_paddr))
                        rs2_rdy_q[i] <= 1'b1;
                end
            end
            if (issue_fire)
                valid_q[sel_idx] <= 1'b0;
            // The alloc target is chosen from registered valid bits, so it never aliases the issued entry.
            if (alloc_fire) begin
                valid_q[free_idx]     <= 1'b1;
                rs1_rdy_q[free_idx]   <= alloc_rs1_rdy_w;
                rs2_rdy_q[free_idx]   <= alloc_rs2_rdy_w;
                rs1_paddr_q[free_idx] <= alloc_rs1_paddr;
                rs2_paddr_q[free_idx] <= alloc_rs2_paddr;
                tag_q[free_idx]       <= alloc_tag;
            end
            count_q <= count_q + CNT_W'(alloc_fire) - CNT_W'(issue_fire);
        end
    end

endmodule
